// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state encodings and default width.
package mult_pkg;

  localparam int MULT_N = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_ctrl_step_counter.sv
// Terminal-count step counter: counts strobes up to TC, then holds until cleared.
module step_counter #(
  parameter int W  = 4,
  parameter int TC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic count_up,
  output logic count_cout
);

  logic [W-1:0] count_q;

  assign count_cout = (count_q == W'(TC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (count_up && !count_cout) begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add unsigned multiplier with start/in_ready request and
// out_valid/out_ready result handshakes; one add-and-shift step per RUN cycle.
module seq_mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product,
  output logic           busy
);

  localparam int CNT_W = $clog2(N + 1);

  state_e         state_q;
  logic [N-1:0]   mcand_q;
  logic [2*N-1:0] acc_q;
  logic [2*N-1:0] acc_d;
  logic [2*N-1:0] product_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [N:0]     sum_d;
  logic           step_clr;
  logic           step_up;
  logic           step_done;

  // Upper half plus (optionally) the multiplicand, carry kept in bit N.
  assign sum_d = acc_q[0] ? ({1'b0, acc_q[2*N-1:N]} + {1'b0, mcand_q})
                          : {1'b0, acc_q[2*N-1:N]};
  assign acc_d = (2*N)'({sum_d, acc_q[N-1:0]} >> 1);

  assign step_clr = (state_q == ST_IDLE) && start;
  assign step_up  = (state_q == ST_RUN) && !step_done;

  step_counter #(
    .W  (CNT_W),
    .TC (N)
  ) u_step_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (step_clr),
    .count_up   (step_up),
    .count_cout (step_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mcand_q    <= in_a;
            acc_q      <= {{N{1'b0}}, in_b};
            state_q    <= ST_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          if (step_done) begin
            state_q     <= ST_DONE;
            product_q   <= acc_q;
            out_valid_q <= 1'b1;
          end else begin
            acc_q <= acc_d;
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here; requests are never queued.
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: N=8 and N=1 instances, directed vectors.
module tb_seq_mult_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_a = '0;
  logic [N-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [2*N-1:0] product;
  logic         busy;

  logic       start1 = 1'b0;
  logic       in_ready1;
  logic [0:0] in_a1 = '0;
  logic [0:0] in_b1 = '0;
  logic       out_valid1;
  logic       out_ready1 = 1'b1;
  logic [1:0] product1;
  logic       busy1;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [2*N-1:0] exp_q[$];
  logic [1:0]     exp1_q[$];

  seq_mult_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  seq_mult_ctrl #(.N(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .product(product1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end else begin
      $display("ok   %s: %0d", nm, act);
    end
  endfunction

  // Monitors: pop the expected product whenever a result is consumed.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("n8_unexpected_product", 32'(product), 32'hFFFF_FFFF);
      else check("n8_product", 32'(product), 32'(exp_q.pop_front()));
    end
    if (!rst && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) check("n1_unexpected_product", 32'(product1), 32'hFFFF_FFFF);
      else check("n1_product", 32'(product1), 32'(exp1_q.pop_front()));
    end
  end

  task automatic accept8(input logic [N-1:0] a, input logic [N-1:0] b,
                         input bit push, input logic [2*N-1:0] expv, output int k);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 32'(t), 32'd0);
    in_a = a;
    in_b = b;
    start = 1'b1;
    if (push) exp_q.push_back(expv);
    @(posedge clk);
    #1;
    k = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid8(output int e);
    int t;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) check("valid_timeout", 32'(t), 32'd0);
    e = cyc;
  endtask

  initial begin
    int k, e, prev, t;
    logic [N-1:0] b2b_a[3] = '{8'd37, 8'd250, 8'd128};
    logic [N-1:0] b2b_b[3] = '{8'd91, 8'd199, 8'd2};
    logic [2*N-1:0] b2b_p[3] = '{16'd3367, 16'd49750, 16'd256};
    logic [1:0] n1_p[4] = '{2'd0, 2'd0, 2'd0, 2'd1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    rst = 1'b0;

    // 1: 13*11, latency and single-cycle valid
    accept8(8'd13, 8'd11, 1'b1, 16'd143, k);
    check("t1_busy_run", 32'(busy), 32'd1);
    check("t1_in_ready_run", 32'(in_ready), 32'd0);
    wait_valid8(e);
    check("t1_latency", 32'(e - k), 32'(N + 1));
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(out_valid), 32'd0);
    check("t1_back_idle", 32'(in_ready), 32'd1);

    // 2: boundary operands
    accept8(8'hFF, 8'hFF, 1'b1, 16'hFE01, k);
    wait_valid8(e);
    accept8(8'd0, 8'h5A, 1'b1, 16'd0, k);
    wait_valid8(e);
    accept8(8'h5A, 8'd0, 1'b1, 16'd0, k);
    wait_valid8(e);

    // 3: stall in DONE for 5 cycles, start ignored meanwhile
    accept8(8'd13, 8'd11, 1'b1, 16'd143, k);
    out_ready = 1'b0;
    wait_valid8(e);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        in_a = 8'd1;
        in_b = 8'd1;
        start = 1'b1;
      end
      if (i == 3) start = 1'b0;
      check("t3_hold_valid", 32'(out_valid), 32'd1);
      check("t3_hold_product", 32'(product), 32'd143);
      check("t3_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_idle", 32'(in_ready), 32'd1);
    check("t3_release_valid", 32'(out_valid), 32'd0);
    repeat (N + 3) @(negedge clk);
    check("t3_start_ignored_busy", 32'(busy), 32'd0);

    // 4: reset at RUN step 4, then a clean multiply
    accept8(8'd200, 8'd3, 1'b0, 16'd0, k);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("t4_rst_in_ready", 32'(in_ready), 32'd1);
    check("t4_rst_out_valid", 32'(out_valid), 32'd0);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    accept8(8'd7, 8'd6, 1'b1, 16'd42, k);
    wait_valid8(e);
    check("t4_latency", 32'(e - k), 32'(N + 1));

    // 5: start held high; N+2 whole cycles lie between accept edges
    @(negedge clk);
    prev = 0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (!in_ready && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) check("t5_accept_timeout", 32'(t), 32'd0);
      in_a = b2b_a[i];
      in_b = b2b_b[i];
      exp_q.push_back(b2b_p[i]);
      @(posedge clk);
      #1;
      if (i > 0) check("t5_accept_spacing", 32'(cyc - prev - 1), 32'(N + 2));
      prev = cyc;
      @(negedge clk);
    end
    start = 1'b0;

    // 6: N=1 instance, all operand pairs
    for (int i = 0; i < 4; i++) begin
      t = 0;
      @(negedge clk);
      while (!in_ready1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready1) check("t6_accept_timeout", 32'(t), 32'd0);
      in_a1 = 1'(i >> 1);
      in_b1 = 1'(i);
      start1 = 1'b1;
      exp1_q.push_back(n1_p[i]);
      @(posedge clk);
      #1;
      k = cyc;
      start1 = 1'b0;
      t = 0;
      @(negedge clk);
      while (!out_valid1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!out_valid1) check("t6_valid_timeout", 32'(t), 32'd0);
      check("t6_latency", 32'(cyc - k), 32'd2);
    end

    // Drain both scoreboards
    t = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_n8", 32'(exp_q.size()), 32'd0);
    check("drain_n1", 32'(exp1_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
